// File: rtl/mux21_arb.sv
// Two-requester arbiter driving a shared 4-bit channel through a registered
// 2:1 mux. Contention alternates ownership every MAXHOLD cycles; a lone
// requester keeps the channel for as long as it asks. All outputs are
// registered, so requests only take effect at clock edges.
module mux21_arb #(
    parameter int MAXHOLD = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_a,
    input  logic [3:0] i_a,
    input  logic       i_req_b,
    input  logic [3:0] i_b,
    output logic       o_gnt_a,
    output logic       o_gnt_b,
    output logic       o_sel,
    output logic [3:0] o_y,
    output logic       o_vld
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    // Hold-counter value at which a contended owner must give way.
    localparam logic [3:0] HOLD_LAST = 4'(MAXHOLD - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_lastB;
    logic       r_gntA;
    logic       r_gntB;
    logic       r_sel;
    logic [3:0] r_y;
    logic       r_vld;

    state_t     w_next;
    logic       w_vldTerm;
    logic       w_enter;

    // Next-owner decision: fairness from IDLE uses the last-served flag,
    // an owner yields early when it drops its request, or at end of hold.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_req_a && i_req_b)
                    w_next = r_lastB ? OWN_A : OWN_B;
                else if (i_req_a)
                    w_next = OWN_A;
                else if (i_req_b)
                    w_next = OWN_B;
                else
                    w_next = IDLE;
            end
            OWN_A: begin
                if (!i_req_a && i_req_b)
                    w_next = OWN_B;
                else if (!i_req_a)
                    w_next = IDLE;
                else if (i_req_b && (r_cnt == HOLD_LAST))
                    w_next = OWN_B;
                else
                    w_next = OWN_A;
            end
            OWN_B: begin
                if (!i_req_b && i_req_a)
                    w_next = OWN_A;
                else if (!i_req_b)
                    w_next = IDLE;
                else if (i_req_a && (r_cnt == HOLD_LAST))
                    w_next = OWN_A;
                else
                    w_next = OWN_B;
            end
            default: w_next = IDLE;
        endcase
        w_vldTerm = ((r_state == OWN_A) && i_req_a) || ((r_state == OWN_B) && i_req_b);
        w_enter   = (w_next != r_state) && (w_next != IDLE);
    end

    // State, grants, select, hold counter, fairness flag and channel data;
    // reset parks the arbiter so that A wins the first contention.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_gntA  <= 1'b0;
            r_gntB  <= 1'b0;
            r_sel   <= 1'b0;
            r_y     <= 4'h0;
            r_vld   <= 1'b0;
            r_cnt   <= 4'h0;
            r_lastB <= 1'b1;
        end else begin
            r_state <= w_next;
            r_gntA  <= (w_next == OWN_A);
            r_gntB  <= (w_next == OWN_B);
            if (w_next == OWN_A)
                r_sel <= 1'b0;
            else if (w_next == OWN_B)
                r_sel <= 1'b1;
            if (w_enter) begin
                r_cnt   <= 4'h0;
                r_lastB <= (w_next == OWN_B);
            end else if ((w_next != IDLE) && (r_cnt < HOLD_LAST)) begin
                r_cnt <= r_cnt + 4'h1;
            end
            r_vld <= w_vldTerm;
            if (w_vldTerm)
                r_y <= r_sel ? i_b : i_a;
        end
    end

    assign o_gnt_a = r_gntA;
    assign o_gnt_b = r_gntB;
    assign o_sel   = r_sel;
    assign o_y     = r_y;
    assign o_vld   = r_vld;

endmodule

// File: tb/tb_mux21_arb.sv
// Directed-vector bench for mux21_arb with MAXHOLD=4: reset, lone requester,
// steady contention, drain to idle, early release and mid-grant reset.
module tb_mux21_arb;

    logic       clk;
    logic       rst_n;
    logic       req_a;
    logic [3:0] a;
    logic       req_b;
    logic [3:0] b;
    logic       gnt_a;
    logic       gnt_b;
    logic       sel;
    logic [3:0] y;
    logic       vld;

    int checks = 0;
    int errors = 0;

    mux21_arb #(.MAXHOLD(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req_a (req_a),
        .i_a     (a),
        .i_req_b (req_b),
        .i_b     (b),
        .o_gnt_a (gnt_a),
        .o_gnt_b (gnt_b),
        .o_sel   (sel),
        .o_y     (y),
        .o_vld   (vld)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of inputs, clock them in, and settle just after the edge.
    task automatic applyStimulus(input logic rstN, input logic reqA, input logic [3:0] aVal,
                                 input logic reqB, input logic [3:0] bVal);
        rst_n = rstN;
        req_a = reqA;
        a     = aVal;
        req_b = reqB;
        b     = bVal;
        @(posedge clk);
        #1;
    endtask

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Directed scenario sequence with hand-computed expectations.
    initial begin
        logic       ownA;
        logic       prevA;
        logic [3:0] expY;

        rst_n = 1'b0; req_a = 1'b0; a = 4'h0; req_b = 1'b0; b = 4'h0;
        #2;

        // Reset held two cycles while A is requesting.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 4'hF, 1'b0, 4'h0);
            checkOutput("rst_gnt_a", {3'b0, gnt_a}, 4'h0);
            checkOutput("rst_gnt_b", {3'b0, gnt_b}, 4'h0);
            checkOutput("rst_vld",   {3'b0, vld},   4'h0);
            checkOutput("rst_y",     y,             4'h0);
            checkOutput("rst_sel",   {3'b0, sel},   4'h0);
        end

        // First edge with reset released grants A; no data yet.
        applyStimulus(1'b1, 1'b1, 4'hF, 1'b0, 4'h0);
        checkOutput("rel_gnt_a", {3'b0, gnt_a}, 4'h1);
        checkOutput("rel_vld",   {3'b0, vld},   4'h0);
        checkOutput("rel_y",     y,             4'h0);

        // Lone requester keeps the grant; data appears one cycle later.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 4'h5, 1'b0, 4'h0);
            checkOutput("solo_gnt_a", {3'b0, gnt_a}, 4'h1);
            checkOutput("solo_gnt_b", {3'b0, gnt_b}, 4'h0);
            checkOutput("solo_vld",   {3'b0, vld},   4'h1);
            checkOutput("solo_y",     y,             4'h5);
        end

        // Reset in the middle of A's grant.
        applyStimulus(1'b0, 1'b1, 4'h5, 1'b0, 4'h0);
        checkOutput("rstA_gnt_a", {3'b0, gnt_a}, 4'h0);
        checkOutput("rstA_y",     y,             4'h0);

        // Continuous contention: 4 cycles A, 4 cycles B, repeating.
        prevA = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            applyStimulus(1'b1, 1'b1, 4'h3, 1'b1, 4'hC);
            ownA = (((n - 1) / 4) % 2) == 0;
            checkOutput("cont_gnt_a", {3'b0, gnt_a}, {3'b0, ownA});
            checkOutput("cont_gnt_b", {3'b0, gnt_b}, {3'b0, ~ownA});
            checkOutput("cont_excl",  {3'b0, gnt_a & gnt_b}, 4'h0);
            checkOutput("cont_sel",   {3'b0, sel},   {3'b0, ~ownA});
            if (n == 1) begin
                checkOutput("cont_vld0", {3'b0, vld}, 4'h0);
            end else begin
                expY = prevA ? 4'h3 : 4'hC;
                checkOutput("cont_vld", {3'b0, vld}, 4'h1);
                checkOutput("cont_y",   y,           expY);
            end
            prevA = ownA;
        end

        // Drain: both drop while B owns; y and sel hold, vld falls.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 4'h7, 1'b0, 4'h8);
            checkOutput("drain_gnt_a", {3'b0, gnt_a}, 4'h0);
            checkOutput("drain_gnt_b", {3'b0, gnt_b}, 4'h0);
            checkOutput("drain_vld",   {3'b0, vld},   4'h0);
            checkOutput("drain_y",     y,             4'hC);
            checkOutput("drain_sel",   {3'b0, sel},   4'h1);
        end

        // Early release: A owns, B arrives, A drops at cnt=1.
        applyStimulus(1'b1, 1'b1, 4'h6, 1'b0, 4'h0);
        checkOutput("er_gnt_a", {3'b0, gnt_a}, 4'h1);
        checkOutput("er_sel",   {3'b0, sel},   4'h0);
        applyStimulus(1'b1, 1'b1, 4'h6, 1'b1, 4'h9);
        checkOutput("er_hold_a", {3'b0, gnt_a}, 4'h1);
        checkOutput("er_y_a",    y,             4'h6);
        applyStimulus(1'b1, 1'b0, 4'h6, 1'b1, 4'h9);
        checkOutput("er_gnt_b",  {3'b0, gnt_b}, 4'h1);
        checkOutput("er_gnt_a0", {3'b0, gnt_a}, 4'h0);
        checkOutput("er_sel_b",  {3'b0, sel},   4'h1);
        applyStimulus(1'b1, 1'b0, 4'h6, 1'b1, 4'h9);
        checkOutput("er_vld_b", {3'b0, vld}, 4'h1);
        checkOutput("er_y_b",   y,           4'h9);

        // Reset pulse while B owns, with both requesting.
        applyStimulus(1'b0, 1'b1, 4'h6, 1'b1, 4'h9);
        checkOutput("rstB_gnt_a", {3'b0, gnt_a}, 4'h0);
        checkOutput("rstB_gnt_b", {3'b0, gnt_b}, 4'h0);
        checkOutput("rstB_sel",   {3'b0, sel},   4'h0);
        checkOutput("rstB_y",     y,             4'h0);
        checkOutput("rstB_vld",   {3'b0, vld},   4'h0);

        // After reset, A wins the first contention.
        applyStimulus(1'b1, 1'b1, 4'h6, 1'b1, 4'h9);
        checkOutput("post_gnt_a", {3'b0, gnt_a}, 4'h1);
        checkOutput("post_gnt_b", {3'b0, gnt_b}, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
